// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : mp1 memory handshake bundle (initiator <-> responder)
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        protocol_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, protocol_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, protocol_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : fixed-latency word memory responder, byte-enable writes.
// Optional MEM_RESPONDER_RAND_LAT_EN adds 0..3 LFSR cycles. Revision 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave mem
);

  localparam int unsigned WORDS    = 2 ** DEPTH_LOG2;
  localparam logic [4:0]  LAT_LOAD = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [WORDS];

  logic                  accept;
  logic                  enter_resp;
  logic [4:0]            load_val;
  logic                  unused_addr_bits;

  assign accept           = (state_q == IDLE) && (mem.mem_read || mem.mem_write);
  assign unused_addr_bits = ^{mem.mem_address[31:DEPTH_LOG2+2], mem.mem_address[1:0]};

`ifdef MEM_RESPONDER_RAND_LAT_EN
  logic [15:0] lfsr_q;

  // Galois form, taps 16,14,13,11; the current value sets this request's extra delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign load_val = LAT_LOAD + {3'b000, lfsr_q[1:0]};
`else
  assign load_val = LAT_LOAD;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d = mem.mem_write;
          idx_d      = mem.mem_address[DEPTH_LOG2+1:2];
          be_d       = mem.mem_byte_enable;
          wdata_d    = mem.mem_wdata;
          cnt_d      = load_val;
          if (mem.mem_read && mem.mem_write) begin
            err_d = 1'b1;
          end
          if (load_val == 5'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Abort has priority even on the final countdown cycle.
        if (is_write_q ? !mem.mem_write : !mem.mem_read) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd1) begin
          cnt_d      = 5'd0;
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      if (enter_resp && !is_write_d) begin
        rdata_q <= mem_q[idx_d];
      end
    end
  end

  // Storage is deliberately not reset; the _d view covers the latency-1 accept-and-commit edge.
  always_ff @(posedge clk) begin
    if (enter_resp && is_write_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) begin
          mem_q[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
        end
      end
    end
  end

  assign mem.mem_resp     = (state_q == RESP);
  assign mem.mem_rdata    = rdata_q;
  assign mem.protocol_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed checks of mem_responder at LATENCY=2 and LATENCY=1
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        rd;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  int n_chk;
  int n_fail;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (ifa.slave)
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (ifb.slave)
  );

  assign ifa.mem_read        = rd & ~sel;
  assign ifa.mem_write       = wr & ~sel;
  assign ifa.mem_byte_enable = be;
  assign ifa.mem_address     = addr;
  assign ifa.mem_wdata       = wdata;
  assign ifb.mem_read        = rd & sel;
  assign ifb.mem_write       = wr & sel;
  assign ifb.mem_byte_enable = be;
  assign ifb.mem_address     = addr;
  assign ifb.mem_wdata       = wdata;

  logic        resp_m;
  logic [31:0] rdata_m;
  assign resp_m  = sel ? ifb.mem_resp  : ifa.mem_resp;
  assign rdata_m = sel ? ifb.mem_rdata : ifa.mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full handshake; request held until mem_resp, then dropped.
  task automatic txn(input logic s, input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d, input int lat,
                     input string tag, output logic [31:0] rdo);
    int got;
    got = -1;
    rdo = 32'h0;
    @(posedge clk); #1;
    sel = s; rd = r; wr = w; be = b; addr = a; wdata = d;
    for (int c = 0; c < 24 && got < 0; c++) begin
      @(negedge clk);
      if (resp_m) begin
        got = c;
        rdo = rdata_m;
      end
    end
    chk({tag, "_latency"}, got, lat);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, resp_m}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int p0, p1, nresp;
    logic [31:0] d0, d1;

    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0;
    be = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_a", {31'd0, ifa.mem_resp}, 32'd0);
    chk("rst_rdata_a", ifa.mem_rdata, 32'h0);
    chk("rst_err_a", {31'd0, ifa.protocol_err}, 32'd0);
    chk("rst_resp_b", {31'd0, ifb.mem_resp}, 32'd0);
    chk("rst_err_b", {31'd0, ifb.protocol_err}, 32'd0);

    // Write then read
    txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 2, "wr10", r);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 2, "rd10", r);
    chk("rd10_data", r, 32'hDEADBEEF);

    // Byte lanes and empty enable
    txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, 2, "pre20", r);
    txn(1'b0, 1'b0, 1'b1, 4'b0100, 32'h20, 32'hAABBCCDD, 2, "lane20", r);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 2, "rd20", r);
    chk("rd20_data", r, 32'h11BB3344);
    txn(1'b0, 1'b0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 2, "be0", r);
    chk("rdata_hold", ifa.mem_rdata, 32'h11BB3344);
    txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 2, "rd20b", r);
    chk("rd20b_data", r, 32'h11BB3344);

    // Abort a read in BUSY
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    rd = 1'b0;
    nresp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ifa.mem_resp) nresp++;
    end
    chk("abort_noresp", nresp, 0);
    chk("abort_rdata", ifa.mem_rdata, 32'h11BB3344);
    txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h12345678, 2, "post_abort", r);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 2, "rd40", r);
    chk("rd40_data", r, 32'h12345678);

    // Read+write conflict
    txn(1'b0, 1'b1, 1'b1, 4'hF, 32'h30, 32'h5, 2, "conflict", r);
    chk("err_set", {31'd0, ifa.protocol_err}, 32'd1);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 2, "rd30", r);
    chk("rd30_data", r, 32'h5);
    chk("err_sticky", {31'd0, ifa.protocol_err}, 32'd1);

    // Back-to-back on LATENCY=1 instance
    txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0, 1, "b_wr0", r);
    txn(1'b1, 1'b0, 1'b1, 4'hF, 32'h4, 32'hB4B4B4B4, 1, "b_wr4", r);
    @(posedge clk); #1;
    sel = 1'b1; rd = 1'b1; addr = 32'h0;
    p0 = -1; p1 = -1; d0 = 32'h0; d1 = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_m) begin
        if (p0 < 0) begin
          p0 = c; d0 = rdata_m;
        end else if (p1 < 0) begin
          p1 = c; d1 = rdata_m;
        end
      end
      @(posedge clk); #1;
      if (p0 >= 0) addr = 32'h4;
      if (p1 >= 0) rd = 1'b0;
    end
    chk("b2b_first", p0, 1);
    chk("b2b_second", p1, 3);
    chk("b2b_data0", d0, 32'hA0A0A0A0);
    chk("b2b_data1", d1, 32'hB4B4B4B4);
    sel = 1'b0;

    // Reset during BUSY of a write
    @(posedge clk); #1;
    wr = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_resp", {31'd0, ifa.mem_resp}, 32'd0);
    @(posedge clk); #1;
    wr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_resp2", {31'd0, ifa.mem_resp}, 32'd0);
    chk("err_cleared", {31'd0, ifa.protocol_err}, 32'd0);
    chk("rdata_cleared", ifa.mem_rdata, 32'h0);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 2, "rd40_after_rst", r);
    chk("no_commit", r, 32'h12345678);

    // Address aliasing
    txn(1'b0, 1'b0, 1'b1, 4'hF, 32'h10000004, 32'h77, 2, "alias_wr", r);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h00000004, 32'h0, 2, "alias_rd", r);
    chk("alias_data", r, 32'h77);
    txn(1'b0, 1'b1, 1'b0, 4'h0, 32'h00001007, 32'h0, 2, "alias_rd2", r);
    chk("alias_data2", r, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
